instr_encoder: RTL and testbench

Sequential instruction encoder/loader that is the write side of the instruction decoder: it accepts field-level instruction requests (cond, op, funct, rn, rd, src2/imm24) over a valid/ready handshake and packs each into a 32-bit instruction word. It writes each word into instruction memory at consecutive addresses. It sits between the test/boot loader and the instruction memory.

---
 rtl/instr_pkg.sv | 29 ++
 rtl/instr_pack.sv | 44 ++++
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder and decoder.
// Holds the op codes, the bit positions of every field in the 32-bit
// instruction word, and the encoder FSM state type.
package instr_pkg;

  // Op field values
  localparam logic [1:0] OP_DP  = 2'b00;  // data-processing
  localparam logic [1:0] OP_MEM = 2'b01;  // memory
  localparam logic [1:0] OP_BR  = 2'b10;  // branch
  localparam logic [1:0] OP_ILL = 2'b11;  // reserved, rejected by the encoder

  // Field LSB positions inside the instruction word
  localparam int COND_LSB     = 28;  // cond   [31:28]
  localparam int OP_LSB       = 26;  // op     [27:26]
  localparam int FUNCT_LSB    = 20;  // funct  [25:20]
  localparam int RN_LSB       = 16;  // rn     [19:16]
  localparam int RD_LSB       = 12;  // rd     [15:12]
  localparam int SRC2_LSB     = 0;   // src2   [11:0]
  localparam int BR_FUNCT_LSB = 24;  // funct[5:4] in a branch, [25:24]
  localparam int IMM24_LSB    = 0;   // imm24  [23:0]

  // Encoder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer.
// Builds the 32-bit instruction word from its fields and flags the
// reserved op code.
//   cond, op, funct, rn, rd, src2, imm24 : instruction fields (inputs)
//   word    : packed 32-bit instruction (output, zero for an illegal op)
//   illegal : op is the reserved value 2'b11 (output)
module instr_pack (
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        illegal
);
  import instr_pkg::*;

  // Field placement by op class; a branch keeps only funct[5:4] and the offset
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    word[COND_LSB +: 4] = cond;
    word[OP_LSB +: 2]   = op;
    case (op)
      OP_DP, OP_MEM: begin
        word[FUNCT_LSB +: 6] = funct;
        word[RN_LSB +: 4]    = rn;
        word[RD_LSB +: 4]    = rd;
        word[SRC2_LSB +: 12] = src2;
      end
      OP_BR: begin
        word[BR_FUNCT_LSB +: 2] = funct[5:4];
        word[IMM24_LSB +: 24]   = imm24;
      end
      default: begin
        word    = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder / loader.
// Accepts field-level requests over valid/ready, packs each into a 32-bit
// word and writes it to instruction memory at consecutive addresses.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart (address, count, full, done, err)
//   in_valid / in_ready / in_last : request handshake, end-of-program mark
//   cond, op, funct, rn, rd, src2, imm24 : instruction fields
//   imem_we, imem_addr, imem_wdata : memory write port
//   count : words written, full : top address written,
//   done  : last word written, err : sticky illegal-op flag
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);
  import instr_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W:0]    count_r;
  logic [31:0]        wdata_r;
  logic               last_r;
  logic               full_r;
  logic               done_r;
  logic               err_r;
  logic [31:0]        word_s;
  logic               illegal_s;
  logic               xfer_s;

  instr_pack u_pack (
    .cond    (cond),
    .op      (op),
    .funct   (funct),
    .rn      (rn),
    .rd      (rd),
    .src2    (src2),
    .imm24   (imm24),
    .word    (word_s),
    .illegal (illegal_s)
  );

  // clr blocks the handshake and any write in its own cycle; both decode from
  // the state register so reset drops them asynchronously
  assign in_ready   = (state_r == IDLE) && !clr;
  assign xfer_s     = in_valid && in_ready;
  assign imem_we    = (state_r == WRITE) && !clr;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign count      = count_r;
  assign full       = full_r;
  assign done       = done_r;
  assign err        = err_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state; an illegal op completes the handshake but stays in IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s && !illegal_s) begin
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WRITE: begin
          if ((addr_r == ADDR_TOP) || last_r) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HOLD:    state_nxt_s = HOLD;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Datapath: word capture, address/count advance, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= BASE_ADDR;
      count_r <= '0;
      wdata_r <= 32'h0000_0000;
      last_r  <= 1'b0;
      full_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (clr) begin
      addr_r  <= BASE_ADDR;
      count_r <= '0;
      last_r  <= 1'b0;
      full_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (xfer_s) begin
        if (illegal_s) begin
          err_r <= 1'b1;
        end else begin
          wdata_r <= word_s;
          last_r  <= in_last;
        end
      end
      if (imem_we) begin
        count_r <= count_r + (ADDR_W + 1)'(1'b1);
        // the top address is held rather than wrapped; HOLD stops further writes
        if (addr_r == ADDR_TOP) begin
          full_r <= 1'b1;
        end else begin
          addr_r <= addr_r + ADDR_W'(1'b1);
        end
        if (last_r) begin
          done_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2): directed program
// sequences with literal expectations plus randomized traffic, all checked
// every cycle against a behavioural model of the loader.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int TOP    = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] BASE = 2'd0;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clr      = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last  = 1'b0;
  logic [3:0]  cond     = 4'd0;
  logic [1:0]  op       = 2'd0;
  logic [5:0]  funct    = 6'd0;
  logic [3:0]  rn       = 4'd0;
  logic [3:0]  rd       = 4'd0;
  logic [11:0] src2     = 12'd0;
  logic [23:0] imm24    = 24'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd),
    .src2(src2), .imm24(imm24),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from field positions, by arithmetic
  function automatic logic [31:0] enc(input logic [3:0] c, input logic [1:0] o,
                                      input logic [5:0] f, input logic [3:0] n,
                                      input logic [3:0] d, input logic [11:0] s,
                                      input logic [23:0] im);
    if (o == 2'b10)
      return (32'(c) << 28) + (32'(o) << 26) + (32'(f / 6'd16) << 24) + 32'(im);
    return (32'(c) << 28) + (32'(o) << 26) + (32'(f) << 20) + (32'(n) << 16)
         + (32'(d) << 12) + 32'(s);
  endfunction

  // ---------------- behavioural model ----------------
  int          m_addr = 0;
  int          m_count = 0;
  bit          m_full = 1'b0, m_done = 1'b0, m_err = 1'b0;
  bit          m_pend = 1'b0, m_pend_last = 1'b0;
  logic [31:0] m_wdata = 32'd0;

  // Model advance on each rising edge
  always @(posedge clk) begin
    if (!rst_n || clr) begin
      m_addr = int'(BASE); m_count = 0;
      m_full = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
      if (!rst_n) m_wdata = 32'd0;
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_count++;
      if (m_addr == TOP) m_full = 1'b1; else m_addr++;
      if (m_pend_last) m_done = 1'b1;
    end else if (in_valid && !m_full && !m_done) begin
      if (op == 2'b11) m_err = 1'b1;
      else begin
        m_pend = 1'b1;
        m_pend_last = in_last;
        m_wdata = enc(cond, op, funct, rn, rd, src2, imm24);
      end
    end
  end

  // Compare DUT against model every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'(BASE));
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_flags", {29'd0, full, done, err}, 32'd0);
    end else begin
      check("in_ready", 32'(in_ready), 32'(!m_pend && !m_full && !m_done && !clr));
      check("imem_we", 32'(imem_we), 32'(m_pend && !clr));
      check("imem_addr", 32'(imem_addr), 32'(m_addr));
      check("imem_wdata", imem_wdata, m_wdata);
      check("count", 32'(count), 32'(m_count));
      check("full", 32'(full), 32'(m_full));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers (start and end at posedge+1) ----------------
  task automatic scramble();
    cond = 4'($urandom); op = 2'($urandom); funct = 6'($urandom);
    rn = 4'($urandom); rd = 4'($urandom); src2 = 12'($urandom); imm24 = 24'($urandom);
    in_last = 1'($urandom);
  endtask

  task automatic xfer(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                      input logic [23:0] im, input logic last, input int budget,
                      output bit ok);
    cond = c; op = o; funct = f; rn = n; rd = d; src2 = s; imm24 = im; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic next_neg();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  bit ok;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // ADD imm
    xfer(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0, 20, ok);
    check("add_hs", 32'(ok), 32'd1);
    @(negedge clk);
    check("add_we", 32'(imem_we), 32'd1);
    check("add_addr", 32'(imem_addr), 32'd0);
    check("add_wdata", imem_wdata, 32'hE282_1005);
    check("add_ready", 32'(in_ready), 32'd0);
    next_neg();
    check("add_count", 32'(count), 32'd1);
    @(posedge clk); #1;

    // LDR then B with in_last
    do_clr();
    xfer(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 12'h004, 24'h0, 1'b0, 20, ok);
    @(negedge clk);
    check("ldr_we", 32'(imem_we), 32'd1);
    check("ldr_addr", 32'(imem_addr), 32'd0);
    check("ldr_wdata", imem_wdata, 32'hE590_3004);
    @(posedge clk); #1;
    xfer(4'hE, 2'b10, 6'b101101, 4'd7, 4'd9, 12'hABC, 24'h000002, 1'b1, 20, ok);
    @(negedge clk);
    check("b_we", 32'(imem_we), 32'd1);
    check("b_addr", 32'(imem_addr), 32'd1);
    check("b_wdata", imem_wdata, 32'hEA00_0002);
    next_neg();
    check("b_done", 32'(done), 32'd1);
    check("b_ready", 32'(in_ready), 32'd0);
    check("b_count", 32'(count), 32'd2);
    @(posedge clk); #1;

    // Fill memory back-to-back
    do_clr();
    for (int k = 0; k <= TOP; k++) begin
      xfer(4'($urandom), 2'($urandom_range(0, 2)), 6'($urandom), 4'($urandom),
           4'($urandom), 12'($urandom), 24'($urandom), 1'b0, 20, ok);
      @(negedge clk);
      check("fill_we", 32'(imem_we), 32'd1);
      check("fill_addr", 32'(imem_addr), 32'(k));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'(TOP + 1));
    @(posedge clk); #1;
    xfer(4'hE, 2'b00, 6'd0, 4'd0, 4'd0, 12'd0, 24'd0, 1'b0, 10, ok);
    check("fill_5th_rejected", 32'(ok), 32'd0);

    // Illegal op, then legal word at the same address
    do_clr();
    xfer(4'hE, 2'b11, 6'd5, 4'd1, 4'd2, 12'h333, 24'h0, 1'b0, 20, ok);
    check("ill_hs", 32'(ok), 32'd1);
    @(negedge clk);
    check("ill_err", 32'(err), 32'd1);
    check("ill_we", 32'(imem_we), 32'd0);
    check("ill_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    xfer(4'h0, 2'b00, 6'd1, 4'd1, 4'd1, 12'h001, 24'h0, 1'b0, 20, ok);
    @(negedge clk);
    check("ill_next_we", 32'(imem_we), 32'd1);
    check("ill_next_addr", 32'(imem_addr), 32'd0);
    @(posedge clk); #1;

    // clr during WRITE
    xfer(4'h1, 2'b01, 6'd2, 4'd3, 4'd4, 12'h055, 24'h0, 1'b0, 20, ok);
    clr = 1'b1;
    @(negedge clk);
    check("clr_we", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_ready", 32'(in_ready), 32'd1);
    check("clr_addr", 32'(imem_addr), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Reset mid-WRITE
    xfer(4'h2, 2'b00, 6'd3, 4'd5, 4'd6, 12'h777, 24'h0, 1'b0, 20, ok);
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_wdata", imem_wdata, 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      scramble();
      in_last = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
